// File: rtl/argo_chan_reader.sv
// argo_chan_reader -- receive-side endpoint of an Argo channel.
//
// Turns a level receive request from a statement FSM into one pop of the
// attached argo_fifo. It absorbs the FIFO's one-cycle synchronous read
// latency and returns the item together with a one-cycle acknowledge.
//
// Optional build macro: ARGO_READER_PREFETCH_EN
//   When defined, the FSM is replaced by a one-entry prefetch holding
//   register. This gives 1-cycle request-to-ack latency and one item every
//   2 cycles. Items leave the FIFO before anyone asks for them, so use this
//   build only on buffered channels.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset (shared with FIFO)
//   i_recv_req        level request, held until o_recv_ack
//   o_recv_ack        one-cycle pulse, o_recv_data valid in that cycle
//   o_recv_data       registered item, held until the next delivery
//   o_blocked         requester is waiting on an empty channel
//   o_recv_count      items delivered since reset (wraps at 2^32)
//   i_fifo_empty      FIFO empty flag
//   o_fifo_rd_en      FIFO pop strobe (combinational, never while empty)
//   i_fifo_rd_data    FIFO read data, valid the cycle after o_fifo_rd_en
//   o_reader_id       READER_ID constant, for debug visibility
module argo_chan_reader #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [15:0] READER_ID  = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_recv_req,
  output logic                  o_recv_ack,
  output logic [DATA_WIDTH-1:0] o_recv_data,
  output logic                  o_blocked,
  output logic [31:0]           o_recv_count,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic [15:0]           o_reader_id
);

  assign o_reader_id = READER_ID;

  logic [DATA_WIDTH-1:0] r_data;
  logic [31:0]           r_count;

  assign o_recv_data  = r_data;
  assign o_recv_count = r_count;

`ifdef ARGO_READER_PREFETCH_EN

  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_valid;
  logic                  r_inflight;
  logic                  r_ack;
  logic                  w_consume;
  logic                  w_pop;

  // The request is ignored while an ack is showing. The requester drops it
  // on the following edge, so the same request is never served twice.
  assign w_consume = i_recv_req && r_hold_valid && !r_ack;

  // A pop may also be launched in the cycle the holding register is being
  // drained. The refill then lands one cycle later, which sustains one item
  // every two cycles.
  assign w_pop = (!r_hold_valid || w_consume) && !r_inflight && !i_fifo_empty;

  assign o_fifo_rd_en = w_pop;
  assign o_recv_ack   = r_ack;
  assign o_blocked    = i_recv_req && !r_hold_valid && !r_inflight && i_fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_inflight   <= 1'b0;
      r_ack        <= 1'b0;
      r_data       <= '0;
      r_count      <= '0;
    end else begin
      r_inflight <= w_pop;
      r_ack      <= w_consume;
      // A fill and a drain cannot coincide. A fill implies a pop last cycle,
      // and that pop happened only while the register was empty or being
      // drained.
      if (r_inflight) begin
        r_hold       <= i_fifo_rd_data;
        r_hold_valid <= 1'b1;
      end else if (w_consume) begin
        r_hold_valid <= 1'b0;
      end
      if (w_consume) begin
        r_data  <= r_hold;
        r_count <= r_count + 32'd1;
      end
    end
  end

`else

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_recv_req && !i_fifo_empty) w_next = S_LATCH;
      S_LATCH: w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs. The request is not looked at in LATCH or ACK. A withdrawn
  // request therefore still completes its pop.
  always_comb begin
    o_fifo_rd_en = 1'b0;
    o_recv_ack   = 1'b0;
    o_blocked    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_fifo_rd_en = i_recv_req && !i_fifo_empty;
        o_blocked    = i_recv_req && i_fifo_empty;
      end
      S_ACK:   o_recv_ack = 1'b1;
      default: ;
    endcase
  end

  // Data and count are captured on the LATCH->ACK edge. Both are therefore
  // already updated in the cycle the ack is shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (r_state == S_LATCH) begin
      r_data  <= i_fifo_rd_data;
      r_count <= r_count + 32'd1;
    end
  end

`endif

endmodule

// File: tb/tb_argo_chan_reader.sv
module tb_argo_chan_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        ack;
  logic [31:0] data;
  logic        blocked;
  logic [31:0] count;
  logic        empty;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [15:0] reader_id;

  logic        wr_en;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  argo_chan_reader #(.DATA_WIDTH(32), .READER_ID(16'h0003)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_recv_req    (req),
    .o_recv_ack    (ack),
    .o_recv_data   (data),
    .o_blocked     (blocked),
    .o_recv_count  (count),
    .i_fifo_empty  (empty),
    .o_fifo_rd_en  (rd_en),
    .i_fifo_rd_data(rd_data),
    .o_reader_id   (reader_id)
  );

  // Behavioural argo_fifo: synchronous RAM read, data one cycle after rd_en.
  logic [31:0] mem [0:15];
  logic [3:0]  wp, rp;
  logic [4:0]  fcnt;
  assign empty = (fcnt == 5'd0);

  always @(posedge clk) begin
    if (rst) begin
      wp <= '0; rp <= '0; fcnt <= '0; rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 4'd1;
      end
      if (rd_en && !empty) begin
        rd_data <= mem[rp];
        rp <= rp + 4'd1;
      end
      fcnt <= fcnt + {4'd0, wr_en} - {4'd0, (rd_en && !empty)};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Move to the next falling edge and check that a pop never hits an empty FIFO.
  task automatic negc();
    @(negedge clk);
    if (rd_en) chk("rd_en_while_empty", {31'd0, empty}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge. The write lands on the next edge.
  task automatic push(input logic [31:0] v);
    wr_en = 1'b1; wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

`ifndef ARGO_READER_PREFETCH_EN
  // Item already in the FIFO: pop now, ack two cycles later.
  task automatic recv_chk(input logic [31:0] exp_d, input logic [31:0] exp_cnt);
    req = 1'b1;
    negc(); chk("pop_rd_en", {31'd0, rd_en}, 32'd1); chk("pop_ack", {31'd0, ack}, 32'd0);
    negc(); chk("latch_ack", {31'd0, ack}, 32'd0);  chk("latch_rd_en", {31'd0, rd_en}, 32'd0);
    negc(); chk("ack", {31'd0, ack}, 32'd1);         chk("ack_data", data, exp_d);
    chk("ack_count", count, exp_cnt);                chk("ack_rd_en", {31'd0, rd_en}, 32'd0);
    req = 1'b0;
    tick();
  endtask
`endif

  typedef struct {
    logic [31:0] val;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];
  logic [31:0] exp_count;

  initial begin
    vecs[0] = '{val: 32'h0000_00A5, gap: 0, exp: 32'h0000_00A5};
    vecs[1] = '{val: 32'hFFFF_FFFF, gap: 2, exp: 32'hFFFF_FFFF};
    vecs[2] = '{val: 32'h0000_0000, gap: 1, exp: 32'h0000_0000};
    vecs[3] = '{val: 32'hDEAD_BEEF, gap: 3, exp: 32'hDEAD_BEEF};

    rst = 1'b1; req = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, idle for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      negc();
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("rst_blocked", {31'd0, blocked}, 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_count", count, 32'd0);
    end
    chk("reader_id", {16'd0, reader_id}, 32'h0000_0003);
    tick();

`ifndef ARGO_READER_PREFETCH_EN
    exp_count = 32'd0;

    // Single items with different idle gaps between push and request.
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].val);
      for (int g = 0; g < vecs[i].gap; g++) begin
        negc(); chk("gap_no_pop", {31'd0, rd_en}, 32'd0);
        tick();
      end
      exp_count = exp_count + 32'd1;
      recv_chk(vecs[i].exp, exp_count);
    end

    // Blocked on an empty FIFO, then a late write.
    req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      negc();
      chk("blk_blocked", {31'd0, blocked}, 32'd1);
      chk("blk_rd_en", {31'd0, rd_en}, 32'd0);
      tick();
    end
    wr_en = 1'b1; wr_data = 32'h0000_1234;
    negc(); chk("blk_before_wr", {31'd0, blocked}, 32'd1);
    tick(); wr_en = 1'b0;
    negc(); chk("blk_drop", {31'd0, blocked}, 32'd0); chk("blk_pop", {31'd0, rd_en}, 32'd1);
    negc(); chk("blk_latch_ack", {31'd0, ack}, 32'd0);
    negc(); chk("blk_ack", {31'd0, ack}, 32'd1); chk("blk_data", data, 32'h0000_1234);
    exp_count = exp_count + 32'd1;
    chk("blk_count", count, exp_count);
    req = 1'b0;
    tick();

    // Burst 1..7. The FIFO stays non-empty during the ACKs, so a pop there
    // would show up.
    for (int k = 1; k <= 7; k++) push(k);
    for (int k = 1; k <= 7; k++) begin
      exp_count = exp_count + 32'd1;
      recv_chk(k, exp_count);
    end
    chk("burst_fifo_cnt", {27'd0, fcnt}, 32'd0);
    chk("burst_empty", {31'd0, empty}, 32'd1);

    // Reset while in LATCH.
    push(32'h0000_0099);
    req = 1'b1;
    negc(); chk("rl_pop", {31'd0, rd_en}, 32'd1);
    tick();
    rst = 1'b1;
    negc(); chk("rl_latch_ack", {31'd0, ack}, 32'd0);
    tick();
    rst = 1'b0; req = 1'b0;
    negc();
    chk("rl_ack", {31'd0, ack}, 32'd0);
    chk("rl_count", count, 32'd0);
    chk("rl_data", data, 32'd0);
    chk("rl_blocked", {31'd0, blocked}, 32'd0);
    negc(); chk("rl_no_late_ack", {31'd0, ack}, 32'd0);
    tick();
    push(32'h0000_0077);
    recv_chk(32'h0000_0077, 32'd1);
`else
    // Prefetch: the pop happens without a request.
    push(32'h0000_0055);
    negc(); chk("pf_pop", {31'd0, rd_en}, 32'd1); chk("pf_no_ack", {31'd0, ack}, 32'd0);
    tick(); tick(); tick();
    req = 1'b1;
    negc(); chk("pf_t_ack", {31'd0, ack}, 32'd0);
    negc(); chk("pf_ack", {31'd0, ack}, 32'd1); chk("pf_data", data, 32'h0000_0055);
    chk("pf_count", count, 32'd1);
    req = 1'b0;
    tick();

    // Two items, request held: ack every 2 cycles.
    push(32'h0000_0066);
    push(32'h0000_0077);
    repeat (4) tick();
    req = 1'b1;
    negc(); chk("pf2_c0_ack", {31'd0, ack}, 32'd0); chk("pf2_refill", {31'd0, rd_en}, 32'd1);
    negc(); chk("pf2_c1_ack", {31'd0, ack}, 32'd1); chk("pf2_d0", data, 32'h0000_0066);
    chk("pf2_cnt0", count, 32'd2);
    negc(); chk("pf2_c2_ack", {31'd0, ack}, 32'd0);
    negc(); chk("pf2_c3_ack", {31'd0, ack}, 32'd1); chk("pf2_d1", data, 32'h0000_0077);
    chk("pf2_cnt1", count, 32'd3);
    req = 1'b0;
    tick();
    req = 1'b1;
    negc(); chk("pf_blocked", {31'd0, blocked}, 32'd1);
    req = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/argo_chan_reader.md
# argo_chan_reader

Receive-side endpoint for Argo channels: a blocking-receive controller between a compiled statement state machine and the read port of an `argo_fifo` instance. It converts a level receive request into a correctly timed FIFO pop, absorbs the FIFO's one-cycle synchronous RAM read latency, and returns the item with a one-cycle acknowledge. One instance exists per receive site per channel. `argo_fifo` is the writer-side storage, and this block is its reader.

## Interface
- `DATA_WIDTH`, default 32: channel item width; must match the attached FIFO.
- `READER_ID`, default 0: 16-bit identifier, readable for debug only.

- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high. Shared with the attached FIFO.
- `recv_req`  in  1  statement FSM is waiting on `x := <-ch`. Level signal; held until `recv_ack`.
- `recv_ack`  out  1  one-cycle pulse; `recv_data` is valid in this cycle.
- `recv_data`  out  DATA_WIDTH  received item, registered; holds its value until the next delivery.
- `blocked`  out  1  `recv_req` is high, no item is available, and no read is in flight.
- `recv_count`  out  32  items delivered since reset; wraps modulo 2^32.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_rd_en`  out  1  FIFO `rd_en`. Combinational; at most one pulse per item.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO `rd_data`. Valid in the cycle after the `fifo_rd_en` cycle.

## Operation
- FSM states: IDLE, LATCH, ACK. The reset state is IDLE.
- IDLE:
  - `fifo_rd_en` = `recv_req && !fifo_empty`.
  - If `fifo_rd_en` is asserted, go to LATCH. Otherwise stay in IDLE.
- LATCH: `recv_data <= fifo_rd_data`, then go to ACK.
- ACK:
  - `recv_ack` = 1 and `recv_count` increments.
  - Go to IDLE.
  - `recv_req` is ignored in this state. The requester drops it on the following edge.
- `blocked` = `recv_req && fifo_empty` in IDLE, and 0 in all other states.
- `fifo_rd_en` is never asserted while `fifo_empty` is 1. This keeps underflow impossible.
- If `recv_req` drops while in LATCH, the pop still completes. ACK is still pulsed, and the item is counted and lost to the requester. Requesters must not withdraw.
- Reset values: `recv_ack` 0, `recv_data` 0, `blocked` 0, `recv_count` 0, `fifo_rd_en` 0, state IDLE.

## Timing
- The request is sampled in cycle t with the FIFO non-empty. Then:
  - `fifo_rd_en` is high in cycle t.
  - Data is latched at the end of cycle t+1.
  - `recv_ack` and `recv_data` are valid in cycle t+2.
- Request-to-ack latency is 2 cycles. Back-to-back throughput is one item per 3 cycles.
- Empty FIFO: the block waits in IDLE. If a write lands at edge e, `empty` falls after e. The pop happens in the cycle after e, and the ack follows 2 cycles after that.
- Reset asserted mid-operation: the FSM returns to IDLE on that edge and any in-flight item is discarded. The FIFO is reset on the same edge, so no partial state survives.

## Configuration
- `ARGO_READER_PREFETCH_EN` defined: the block adds a one-entry holding register `hold`/`hold_valid`, with an independent prefetch engine.
  - Prefetch pops whenever `!hold_valid && !fetch_in_flight && !fifo_empty`, regardless of `recv_req`.
  - The returned data fills `hold` in the next cycle.
  - When `recv_req && hold_valid`, `recv_data <= hold` and `recv_ack` is pulsed on the next cycle, for 1-cycle latency.
  - `hold` may refill in the same cycle it is consumed, giving a sustained rate of one item per 2 cycles.
  - `blocked` = `recv_req && !hold_valid && !fetch_in_flight && fifo_empty`.
  - Semantic note: an item leaves the FIFO before a receiver asks for it. Use this only on buffered channels.
- Undefined: the FSM described in Operation, with no prefetch.

## Test plan
- Reset, then idle for 5 cycles. All outputs must be 0, `recv_count` 0, and no `fifo_rd_en` pulse.
- Push 0xA5 into the FIFO, then assert `recv_req` at cycle 10. Required: `fifo_rd_en` at 10, `recv_ack` at 12 with `recv_data`=0xA5, `recv_count`=1.
- `recv_req` high on an empty FIFO for 8 cycles. Required: `blocked`=1 throughout. Then write 0x1234. Required: `blocked` drops, and `recv_ack` arrives 3 cycles after the write edge with data 0x1234.
- Push 1..7, with `recv_req` held and re-asserted after each ack. Required: 7 acks in order 1..7, `recv_count`=7, no `fifo_rd_en` while empty, and the FIFO item count is 0 at the end.
- Assert `rst` in LATCH. Required: no ack, state IDLE, and `recv_count` 0.
- With `ARGO_READER_PREFETCH_EN`: preload 0x55 and wait 3 cycles so `hold_valid`=1. Then assert `recv_req` at t. Required: ack at t+1 with 0x55.
